// File: rtl/sig_gen_pkg.sv
// -----------------------------------------------------------------------------
// sig_gen_pkg
//   Shared definitions for the test-signal pair generator.
//   - DEF_CNT_W  : default width of the period/high/delay/burst fields
//   - MIN_PERIOD : smallest period the generator will run (shorter requests
//                  are raised to this value when the config is latched)
//   - state_t    : burst controller states
// -----------------------------------------------------------------------------
package sig_gen_pkg;

    localparam int DEF_CNT_W  = 32;
    localparam int MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : sig_gen_pkg

// File: rtl/sig_pair_gen_phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
//   Wrapping 0..limit-1 counter with a registered "count < high" output.
//   The compare is taken on the value the counter is about to hold, so hit
//   lines up with cnt in the same cycle.
//
// Ports:
//   fbase     in   clock, posedge
//   rst       in   asynchronous active-high reset
//   load      in   load load_val this edge (start of a run)
//   adv       in   advance/wrap this edge (run continues)
//   gate      in   qualifies hit this edge (0 forces hit low)
//   load_val  in   CNT_W  value loaded on load
//   limit     in   CNT_W  wrap modulus P (count runs 0..P-1)
//   high      in   CNT_W  hit is high while count < high
//   wrap      out  counter currently sits at limit-1
//   hit       out  registered (count < high) & gate; low when neither load
//                  nor adv is asserted (counter parked at 0)
// -----------------------------------------------------------------------------
module phase_counter
    import sig_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             fbase,
    input  logic             rst,
    input  logic             load,
    input  logic             adv,
    input  logic             gate,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] limit,
    input  logic [CNT_W-1:0] high,
    output logic             wrap,
    output logic             hit
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    assign wrap = (cnt == limit - CNT_W'(1));

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cnt_next = '0;
        if (load) begin
            cnt_next = load_val;
        end else if (adv) begin
            cnt_next = wrap ? '0 : cnt + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge fbase or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            hit <= 1'b0;
        end else begin
            cnt <= cnt_next;
            hit <= (load || adv) && gate && (cnt_next < high);
        end
    end

endmodule : phase_counter

// File: rtl/sig_pair_gen.sv
// -----------------------------------------------------------------------------
// sig_pair_gen
//   Programmable square-wave source: fx and a copy fdelay lagging it by an
//   exact number of fbase cycles. Runs a burst of n_periods periods, or
//   continuously when n_periods is 0, until stop_sig.
//
// Ports:
//   fbase      in   1      system clock (200 MHz), posedge
//   rst        in   1      asynchronous active-high reset
//   start_sig  in   1      level, sampled only in IDLE, launches a burst
//   stop_sig   in   1      level, aborts a run (and blocks start in IDLE)
//   period     in   CNT_W  fx period in fbase cycles (min 2)
//   high_cnt   in   CNT_W  fx high time (clamped to the period)
//   delay_cnt  in   CNT_W  fdelay lag (clamped to period-1)
//   n_periods  in   CNT_W  burst length in periods, 0 = continuous
//   fx         out  1      generated signal, registered
//   fdelay     out  1      fx delayed by delay_cnt cycles, registered
//   busy       out  1      high while running
//   done_sig   out  1      one-cycle pulse at natural burst end
//   LED        out  1      mirror of busy
// -----------------------------------------------------------------------------
module sig_pair_gen
    import sig_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             fbase,
    input  logic             rst,
    input  logic             start_sig,
    input  logic             stop_sig,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high_cnt,
    input  logic [CNT_W-1:0] delay_cnt,
    input  logic [CNT_W-1:0] n_periods,
    output logic             fx,
    output logic             fdelay,
    output logic             busy,
    output logic             done_sig,
    output logic             LED
);

    state_t           state;

    // Config latched at launch; later input changes do not affect the run.
    logic [CNT_W-1:0] sh_p;
    logic [CNT_W-1:0] sh_h;
    logic [CNT_W-1:0] sh_n;

    logic [CNT_W-1:0] pcount;     // completed periods, saturating
    logic             armed;      // fdelay has passed its first rising point
    logic             armed_next;

    logic [CNT_W-1:0] in_p;
    logic [CNT_W-1:0] in_h;
    logic [CNT_W-1:0] in_d;
    logic [CNT_W-1:0] q_load;
    logic [CNT_W-1:0] cur_p;
    logic [CNT_W-1:0] cur_h;

    logic             accept;
    logic             end_now;
    logic             adv;
    logic             pc_wrap;
    logic             qc_wrap;

    // Clamp the live inputs; only used on the launch edge.
    always_comb begin
        in_p = (period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period;
        in_h = (high_cnt > in_p) ? in_p : high_cnt;
        in_d = (delay_cnt > in_p - CNT_W'(1)) ? in_p - CNT_W'(1) : delay_cnt;
        // Start the lagging counter D cycles "behind" zero: (P-D) mod P.
        q_load = (in_d == '0) ? '0 : in_p - in_d;
    end

    assign accept  = (state == IDLE) && start_sig && !stop_sig;
    assign end_now = (state == RUN) && (sh_n != '0) && pc_wrap
                     && (pcount == sh_n - CNT_W'(1));
    assign adv     = (state == RUN) && !stop_sig && !end_now;

    // On the launch edge the shadows are not loaded yet, so use the inputs.
    assign cur_p = accept ? in_p : sh_p;
    assign cur_h = accept ? in_h : sh_h;

    // fdelay stays low until the lagging counter first wraps to 0, so the
    // end of a "previous" high phase never leaks in before the first edge.
    always_comb begin
        armed_next = 1'b0;
        if (accept) begin
            armed_next = (in_d == '0);
        end else if (adv) begin
            armed_next = armed || qc_wrap;
        end
    end

    phase_counter #(.CNT_W(CNT_W)) u_fx_cnt (
        .fbase    (fbase),
        .rst      (rst),
        .load     (accept),
        .adv      (adv),
        .gate     (1'b1),
        .load_val ('0),
        .limit    (cur_p),
        .high     (cur_h),
        .wrap     (pc_wrap),
        .hit      (fx)
    );

    phase_counter #(.CNT_W(CNT_W)) u_dly_cnt (
        .fbase    (fbase),
        .rst      (rst),
        .load     (accept),
        .adv      (adv),
        .gate     (armed_next),
        .load_val (q_load),
        .limit    (cur_p),
        .high     (cur_h),
        .wrap     (qc_wrap),
        .hit      (fdelay)
    );

    always_ff @(posedge fbase or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done_sig <= 1'b0;
            sh_p     <= '0;
            sh_h     <= '0;
            sh_n     <= '0;
            pcount   <= '0;
            armed    <= 1'b0;
        end else begin
            armed <= armed_next;
            case (state)
                IDLE: begin
                    done_sig <= 1'b0;
                    if (accept) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        sh_p   <= in_p;
                        sh_h   <= in_h;
                        sh_n   <= n_periods;
                        pcount <= '0;
                    end
                end
                RUN: begin
                    if (stop_sig) begin
                        // Abort: no done pulse.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (end_now) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done_sig <= 1'b1;
                    end else if (pc_wrap && (pcount != '1)) begin
                        pcount <= pcount + CNT_W'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    done_sig <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done_sig <= 1'b0;
                end
            endcase
        end
    end

    assign LED = busy;

endmodule : sig_pair_gen

// File: tb/tb_sig_pair_gen.sv
// -----------------------------------------------------------------------------
// tb_sig_pair_gen
//   Self-checking bench for sig_pair_gen. A cycle-level reference model keeps
//   only "which state, how many cycles since launch, clamped config" and
//   derives fx/fdelay with modular arithmetic.
// -----------------------------------------------------------------------------
module tb_sig_pair_gen;

    localparam int W = 32;

    logic         fbase = 1'b0;
    logic         rst;
    logic         start_sig;
    logic         stop_sig;
    logic [W-1:0] period;
    logic [W-1:0] high_cnt;
    logic [W-1:0] delay_cnt;
    logic [W-1:0] n_periods;
    logic         fx;
    logic         fdelay;
    logic         busy;
    logic         done_sig;
    logic         LED;

    sig_pair_gen #(.CNT_W(W)) dut (
        .fbase     (fbase),
        .rst       (rst),
        .start_sig (start_sig),
        .stop_sig  (stop_sig),
        .period    (period),
        .high_cnt  (high_cnt),
        .delay_cnt (delay_cnt),
        .n_periods (n_periods),
        .fx        (fx),
        .fdelay    (fdelay),
        .busy      (busy),
        .done_sig  (done_sig),
        .LED       (LED)
    );

    always #5 fbase = ~fbase;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int     m_state;   // 0 idle, 1 run, 2 done
    longint m_k;       // cycles since launch
    longint m_p, m_h, m_d, m_n;

    task automatic model_reset();
        m_state = 0;
        m_k     = 0;
    endtask

    task automatic model_step();
        longint p, h, d;
        case (m_state)
            0: if (start_sig && !stop_sig) begin
                p = (longint'(period) < 2) ? 2 : longint'(period);
                h = (longint'(high_cnt) > p) ? p : longint'(high_cnt);
                d = (longint'(delay_cnt) > p - 1) ? p - 1 : longint'(delay_cnt);
                m_p = p; m_h = h; m_d = d; m_n = longint'(n_periods);
                m_k = 0;
                m_state = 1;
            end
            1: begin
                if (stop_sig) m_state = 0;
                else if (m_n != 0 && m_k == m_n * m_p - 1) m_state = 2;
                else m_k++;
            end
            default: m_state = 0;
        endcase
    endtask

    function automatic logic [4:0] exp_outs();
        logic f, d, b, dn;
        f = 1'b0; d = 1'b0; b = 1'b0; dn = 1'b0;
        if (m_state == 1) begin
            f = (m_k % m_p) < m_h;
            d = (m_k >= m_d) && (((m_k - m_d) % m_p) < m_h);
            b = 1'b1;
        end else if (m_state == 2) begin
            dn = 1'b1;
        end
        return {f, d, b, dn, b};
    endfunction

    // ---------------- per-cycle stats ----------------
    int   st_fxr, st_fdr, st_busy, st_done, st_done_at, st_idx;
    logic prev_fx, prev_fd;

    task automatic clear_stats();
        st_fxr = 0; st_fdr = 0; st_busy = 0; st_done = 0;
        st_done_at = -1; st_idx = 0;
        prev_fx = fx; prev_fd = fdelay;
    endtask

    // One clock: model advances on the edge, outputs compared on negedge.
    task automatic cycle(input string tag);
        @(posedge fbase);
        if (rst) model_reset();
        else     model_step();
        @(negedge fbase);
        check(tag, {59'd0, fx, fdelay, busy, done_sig, LED}, {59'd0, exp_outs()});
        if (fx && !prev_fx)     st_fxr++;
        if (fdelay && !prev_fd) st_fdr++;
        if (busy)               st_busy++;
        if (done_sig) begin
            st_done++;
            st_done_at = st_idx;
        end
        prev_fx = fx;
        prev_fd = fdelay;
        st_idx++;
    endtask

    task automatic set_cfg(input int p, input int h, input int d, input int n);
        period    = W'(p);
        high_cnt  = W'(h);
        delay_cnt = W'(d);
        n_periods = W'(n);
    endtask

    typedef struct {
        int p, h, d, n;
        int fx_rises, fd_rises, busy_cyc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{p: 10, h: 3,  d: 0,  n: 4, fx_rises: 4, fd_rises: 4, busy_cyc: 40};
        vecs[1] = '{p: 20, h: 10, d: 5,  n: 3, fx_rises: 3, fd_rises: 3, busy_cyc: 60};
        vecs[2] = '{p: 1,  h: 1,  d: 0,  n: 3, fx_rises: 3, fd_rises: 3, busy_cyc: 6};
        vecs[3] = '{p: 10, h: 0,  d: 0,  n: 2, fx_rises: 0, fd_rises: 0, busy_cyc: 20};
        vecs[4] = '{p: 20, h: 25, d: 0,  n: 2, fx_rises: 1, fd_rises: 1, busy_cyc: 40};
        vecs[5] = '{p: 20, h: 5,  d: 50, n: 2, fx_rises: 2, fd_rises: 2, busy_cyc: 40};

        rst = 1'b1;
        start_sig = 1'b0;
        stop_sig  = 1'b0;
        set_cfg(0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge fbase);
        check("reset_state", {59'd0, fx, fdelay, busy, done_sig, LED}, 64'd0);
        rst = 1'b0;
        repeat (2) cycle("idle");

        // ---- table-driven bursts ----
        for (int i = 0; i < 6; i++) begin
            set_cfg(vecs[i].p, vecs[i].h, vecs[i].d, vecs[i].n);
            start_sig = 1'b1;
            clear_stats();
            cycle("vec_outs");
            start_sig = 1'b0;
            for (int c = 0; c < vecs[i].busy_cyc + 4; c++) cycle("vec_outs");
            check("vec_fx_rises", st_fxr, vecs[i].fx_rises);
            check("vec_fd_rises", st_fdr, vecs[i].fd_rises);
            check("vec_busy_cyc", st_busy, vecs[i].busy_cyc);
            check("vec_done_cnt", st_done, 1);
            check("vec_done_at", st_done_at, vecs[i].busy_cyc);
        end

        // ---- continuous mode, then stop ----
        set_cfg(8, 4, 0, 0);
        start_sig = 1'b1;
        clear_stats();
        cycle("cont_outs");
        start_sig = 1'b0;
        repeat (999) cycle("cont_outs");
        check("cont_fx_rises", st_fxr, 125);
        stop_sig = 1'b1;
        cycle("stop_outs");
        check("stop_fx_low", {62'd0, fx, fdelay}, 64'd0);
        check("stop_busy_low", busy, 1'b0);
        stop_sig = 1'b0;
        repeat (5) cycle("after_stop");
        check("stop_no_done", st_done, 0);

        // ---- asynchronous reset mid-burst, then relaunch ----
        set_cfg(10, 3, 0, 4);
        start_sig = 1'b1;
        cycle("pre_rst");
        start_sig = 1'b0;
        repeat (11) cycle("pre_rst");
        check("pre_rst_active", {62'd0, fx, busy}, 64'd3);
        #1 rst = 1'b1;
        #1 check("rst_async", {59'd0, fx, fdelay, busy, done_sig, LED}, 64'd0);
        model_reset();
        repeat (2) cycle("in_rst");
        rst = 1'b0;
        set_cfg(6, 2, 1, 2);
        start_sig = 1'b1;
        clear_stats();
        cycle("relaunch");
        start_sig = 1'b0;
        repeat (16) cycle("relaunch");
        check("relaunch_busy", st_busy, 12);
        check("relaunch_fd_rises", st_fdr, 2);
        check("relaunch_done", st_done, 1);

        // ---- config change during run is ignored ----
        set_cfg(10, 3, 0, 2);
        start_sig = 1'b1;
        clear_stats();
        cycle("cfg_hold");
        start_sig = 1'b0;
        repeat (3) cycle("cfg_hold");
        set_cfg(4, 1, 2, 1);
        repeat (24) cycle("cfg_hold");
        check("cfg_hold_busy", st_busy, 20);
        check("cfg_hold_rises", st_fxr, 2);

        // ---- start+stop together in IDLE: stays idle ----
        start_sig = 1'b1;
        stop_sig  = 1'b1;
        clear_stats();
        repeat (3) cycle("start_stop");
        check("start_stop_idle", st_busy, 0);
        start_sig = 1'b0;
        stop_sig  = 1'b0;
        cycle("idle");

        // ---- start held through DONE: relaunch after one idle cycle ----
        set_cfg(4, 2, 0, 1);
        start_sig = 1'b1;
        clear_stats();
        repeat (14) cycle("start_held");
        start_sig = 1'b0;
        repeat (6) cycle("start_held");
        check("held_done_cnt", st_done, 3);
        check("held_busy", st_busy, 12);

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 3000; c++) begin
            start_sig = ($urandom_range(0, 3) == 0);
            stop_sig  = ($urandom_range(0, 49) == 0);
            set_cfg($urandom_range(0, 12), $urandom_range(0, 14),
                    $urandom_range(0, 14), $urandom_range(0, 3));
            cycle("rand_outs");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sig_pair_gen
